// File: rtl/rally_ctrl.sv
// rally_ctrl: 16-LED tennis rally game controller.
// Arbitrates the serve, steps the ball at a per-hit accelerating rate,
// judges hits, misses and early swings, keeps score and latches game-over.
// P1 owns led[15], P2 owns led[0]. dir = 0 means the ball travels toward P2.
module rally_ctrl #(
  parameter int TICK_DIV  = 4000000,
  parameter int SPEEDUP   = 400000,
  parameter int MIN_DIV   = 1000000,
  parameter int WIN_SCORE = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        button1,
  input  logic        button2,
  output logic [15:0] led,
  output logic [3:0]  score1,
  output logic [3:0]  score2,
  output logic        serve_turn,
  output logic        game_over
);

  localparam int W = $clog2(TICK_DIV + 1);
  localparam logic [W-1:0] TICK_DIV_W = W'(TICK_DIV);
  localparam logic [W-1:0] TICK_M1_W  = W'(TICK_DIV - 1);
  localparam logic [W-1:0] MIN_DIV_W  = W'(MIN_DIV);
  localparam logic [W-1:0] SPEEDUP_W  = W'(SPEEDUP);
  localparam logic [3:0]   WIN_W      = 4'(WIN_SCORE);

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_MOVE  = 2'd1,
    ST_POINT = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  // Score increment that sticks at the 4-bit ceiling.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    if (v == 4'd15) begin
      return 4'd15;
    end else begin
      return v + 4'd1;
    end
  endfunction

  state_t       state_r,   state_s;
  logic [3:0]   pos_r,     pos_s;
  logic         dir_r,     dir_s;
  logic [W-1:0] div_cnt_r, div_cnt_s;
  logic [W-1:0] cur_div_r, cur_div_s;
  logic [3:0]   score1_r,  score1_s;
  logic [3:0]   score2_r,  score2_s;
  logic         turn_r,    turn_s;
  logic         hitter_r,  hitter_s;   // 0 = P1, 1 = P2
  logic         winner_r,  winner_s;   // winner of the latest point
  logic         btn1_q_r,  btn2_q_r;

  logic         press1_s, press2_s;
  logic         tick_s, at_end_s, recv_press_s, win_reached_s;
  logic         award_s, award_to_s;
  logic [W-1:0] sped_div_s;

  // Button history for edge detection; captured even during reset so a
  // button held through reset does not register as a fresh press.
  always_ff @(posedge clk) begin
    btn1_q_r <= button1;
    btn2_q_r <= button2;
  end

  // Press strobes, step tick, receiver view and the floored speed-up value.
  always_comb begin
    press1_s      = button1 & ~btn1_q_r;
    press2_s      = button2 & ~btn2_q_r;
    tick_s        = (div_cnt_r == (cur_div_r - W'(1)));
    at_end_s      = dir_r ? (pos_r == 4'd15) : (pos_r == 4'd0);
    recv_press_s  = dir_r ? press1_s : press2_s;
    win_reached_s = winner_r ? (score2_r == WIN_W) : (score1_r == WIN_W);
    if (32'(cur_div_r) >= (32'(MIN_DIV) + 32'(SPEEDUP))) begin
      sped_div_s = cur_div_r - SPEEDUP_W;
    end else begin
      sped_div_s = MIN_DIV_W;
    end
  end

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_SERVE;
      pos_r     <= 4'd15;
      dir_r     <= 1'b0;
      div_cnt_r <= '0;
      cur_div_r <= TICK_DIV_W;
      score1_r  <= 4'd0;
      score2_r  <= 4'd0;
      turn_r    <= 1'b0;
      hitter_r  <= 1'b0;
      winner_r  <= 1'b0;
    end else begin
      state_r   <= state_s;
      pos_r     <= pos_s;
      dir_r     <= dir_s;
      div_cnt_r <= div_cnt_s;
      cur_div_r <= cur_div_s;
      score1_r  <= score1_s;
      score2_r  <= score2_s;
      turn_r    <= turn_s;
      hitter_r  <= hitter_s;
      winner_r  <= winner_s;
    end
  end

  // Next-state logic: serve, flight judgement, point hold and game-over.
  always_comb begin
    state_s    = state_r;
    pos_s      = pos_r;
    dir_s      = dir_r;
    div_cnt_s  = div_cnt_r;
    cur_div_s  = cur_div_r;
    score1_s   = score1_r;
    score2_s   = score2_r;
    turn_s     = turn_r;
    hitter_s   = hitter_r;
    winner_s   = winner_r;
    award_s    = 1'b0;
    award_to_s = 1'b0;

    case (state_r)
      ST_SERVE: begin
        if (!turn_r && press1_s) begin
          state_s   = ST_MOVE;
          dir_s     = 1'b0;
          div_cnt_s = '0;
          cur_div_s = TICK_DIV_W;
          hitter_s  = 1'b0;
        end else if (turn_r && press2_s) begin
          state_s   = ST_MOVE;
          dir_s     = 1'b1;
          div_cnt_s = '0;
          cur_div_s = TICK_DIV_W;
          hitter_s  = 1'b1;
        end else begin
          pos_s = turn_r ? 4'd0 : 4'd15;
        end
      end

      ST_MOVE: begin
        // A receiver press outranks a coincident tick.
        if (recv_press_s) begin
          if (at_end_s) begin
            dir_s     = ~dir_r;
            hitter_s  = ~dir_r;
            cur_div_s = sped_div_s;
            div_cnt_s = '0;
          end else begin
            award_s    = 1'b1;
            award_to_s = dir_r;      // early swing: the non-receiver scores
          end
        end else if (tick_s) begin
          if (at_end_s) begin
            award_s    = 1'b1;
            award_to_s = hitter_r;   // miss: last hitter scores
          end else begin
            pos_s     = dir_r ? (pos_r + 4'd1) : (pos_r - 4'd1);
            div_cnt_s = '0;
          end
        end else begin
          div_cnt_s = div_cnt_r + W'(1);
        end
      end

      ST_POINT: begin
        if (div_cnt_r == TICK_M1_W) begin
          div_cnt_s = '0;
          if (win_reached_s) begin
            state_s = ST_OVER;
          end else begin
            state_s = ST_SERVE;
            turn_s  = ~turn_r;
            pos_s   = turn_r ? 4'd15 : 4'd0;
          end
        end else begin
          div_cnt_s = div_cnt_r + W'(1);
        end
      end

      ST_OVER: begin
        state_s = ST_OVER;
      end

      default: begin
        state_s = ST_SERVE;
      end
    endcase

    if (award_s) begin
      winner_s  = award_to_s;
      state_s   = ST_POINT;
      div_cnt_s = '0;
      if (award_to_s) begin
        score2_s = sat_inc(score2_r);
      end else begin
        score1_s = sat_inc(score1_r);
      end
    end else begin
      winner_s = winner_r;
    end
  end

  // LED bar decode of the registered state.
  always_comb begin
    case (state_r)
      ST_SERVE: led = 16'd1 << pos_r;
      ST_MOVE:  led = 16'd1 << pos_r;
      ST_POINT: led = 16'hFFFF;
      ST_OVER:  led = winner_r ? 16'h00FF : 16'hFF00;
      default:  led = 16'h0000;
    endcase
  end

  assign score1     = score1_r;
  assign score2     = score2_r;
  assign serve_turn = turn_r;
  assign game_over  = (state_r == ST_OVER);

endmodule

// File: tb/tb_rally_ctrl.sv
// Directed bench for rally_ctrl with small timing parameters.
module tb_rally_ctrl;

  logic        clk;
  logic        reset;
  logic        button1;
  logic        button2;
  logic [15:0] led;
  logic [3:0]  score1;
  logic [3:0]  score2;
  logic        serve_turn;
  logic        game_over;

  int n_cmp = 0;
  int n_bad = 0;

  rally_ctrl #(
    .TICK_DIV (4),
    .SPEEDUP  (1),
    .MIN_DIV  (2),
    .WIN_SCORE(3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .button1   (button1),
    .button2   (button2),
    .led       (led),
    .score1    (score1),
    .score2    (score2),
    .serve_turn(serve_turn),
    .game_over (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs held for n cycles, then the expected outputs.
  typedef struct packed {
    logic        rst;
    logic        b1;
    logic        b2;
    logic [7:0]  n;
    logic [15:0] led;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic        turn;
    logic        over;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic b1, input logic b2,
                              input int n, input logic [15:0] l,
                              input logic [3:0] s1, input logic [3:0] s2,
                              input logic turn, input logic over);
    vec_t v;
    v.rst = rst; v.b1 = b1; v.b2 = b2; v.n = 8'(n);
    v.led = l; v.s1 = s1; v.s2 = s2; v.turn = turn; v.over = over;
    return v;
  endfunction

  task automatic cmp(input string tag, input string fld,
                     input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s %s: got %h expected %h", tag, fld, act, exp);
    end
  endtask

  task automatic check(input string tag, input vec_t v);
    cmp(tag, "led", led, v.led);
    cmp(tag, "score1", {12'd0, score1}, {12'd0, v.s1});
    cmp(tag, "score2", {12'd0, score2}, {12'd0, v.s2});
    cmp(tag, "serve_turn", {15'd0, serve_turn}, {15'd0, v.turn});
    cmp(tag, "game_over", {15'd0, game_over}, {15'd0, v.over});
  endtask

  task automatic apply(input string tag, input vec_t v);
    reset   = v.rst;
    button1 = v.b1;
    button2 = v.b2;
    repeat (int'(v.n)) @(posedge clk);
    #1;
    check(tag, v);
  endtask

  initial begin
    reset = 1'b1; button1 = 1'b0; button2 = 1'b0;

    // Run 1: reset, serve/miss, ignored presses
    tbl.push_back(mk(1,0,0, 2,16'h8000,0,0,0,0));
    tbl.push_back(mk(0,0,1, 1,16'h8000,0,0,0,0));  // non-server press
    tbl.push_back(mk(0,0,0, 1,16'h8000,0,0,0,0));
    tbl.push_back(mk(0,1,0, 1,16'h8000,0,0,0,0));  // P1 serves
    tbl.push_back(mk(0,0,0, 3,16'h8000,0,0,0,0));
    tbl.push_back(mk(0,0,0, 1,16'h4000,0,0,0,0));
    tbl.push_back(mk(0,1,0, 1,16'h4000,0,0,0,0));  // non-receiver press
    tbl.push_back(mk(0,0,0, 3,16'h2000,0,0,0,0));
    tbl.push_back(mk(0,0,0,52,16'h0001,0,0,0,0));
    tbl.push_back(mk(0,0,0, 3,16'h0001,0,0,0,0));
    tbl.push_back(mk(0,0,0, 1,16'hFFFF,1,0,0,0));  // P2 missed
    tbl.push_back(mk(0,0,0, 3,16'hFFFF,1,0,0,0));
    tbl.push_back(mk(0,0,0, 1,16'h0001,1,0,1,0));  // P2 to serve
    // held buttons across the serve, hit with speed-up, early swing
    tbl.push_back(mk(0,1,0, 3,16'h0001,1,0,1,0));
    tbl.push_back(mk(0,1,1, 1,16'h0001,1,0,1,0));  // P2 serves
    tbl.push_back(mk(0,1,1, 3,16'h0001,1,0,1,0));
    tbl.push_back(mk(0,1,1, 1,16'h0002,1,0,1,0));
    tbl.push_back(mk(0,0,0, 4,16'h0004,1,0,1,0));
    tbl.push_back(mk(0,0,0,52,16'h8000,1,0,1,0));
    tbl.push_back(mk(0,1,0, 1,16'h8000,1,0,1,0));  // P1 hits, period 3
    tbl.push_back(mk(0,0,0, 2,16'h8000,1,0,1,0));
    tbl.push_back(mk(0,0,0, 1,16'h4000,1,0,1,0));
    tbl.push_back(mk(0,0,0,18,16'h0100,1,0,1,0));
    tbl.push_back(mk(0,0,1, 1,16'hFFFF,2,0,1,0));  // P2 early swing
    tbl.push_back(mk(0,0,0, 3,16'hFFFF,2,0,1,0));
    tbl.push_back(mk(0,0,0, 1,16'h8000,2,0,0,0));
    // simultaneous press, repeated speed-up down to the floor, final point
    tbl.push_back(mk(0,1,0, 1,16'h8000,2,0,0,0));
    tbl.push_back(mk(0,0,0,60,16'h0001,2,0,0,0));
    tbl.push_back(mk(0,1,1, 1,16'h0001,2,0,0,0));  // counted as P2 hit
    tbl.push_back(mk(0,0,0, 2,16'h0001,2,0,0,0));
    tbl.push_back(mk(0,0,0, 1,16'h0002,2,0,0,0));
    tbl.push_back(mk(0,0,0,42,16'h8000,2,0,0,0));
    tbl.push_back(mk(0,1,0, 1,16'h8000,2,0,0,0));  // P1 hit, period 2
    tbl.push_back(mk(0,0,0, 1,16'h8000,2,0,0,0));
    tbl.push_back(mk(0,0,0, 1,16'h4000,2,0,0,0));
    tbl.push_back(mk(0,0,0,28,16'h0001,2,0,0,0));
    tbl.push_back(mk(0,0,1, 1,16'h0001,2,0,0,0));  // P2 hit, floor holds 2
    tbl.push_back(mk(0,0,0, 1,16'h0001,2,0,0,0));
    tbl.push_back(mk(0,0,0, 1,16'h0002,2,0,0,0));
    tbl.push_back(mk(0,0,0,28,16'h8000,2,0,0,0));
    tbl.push_back(mk(0,1,0, 1,16'h8000,2,0,0,0));
    tbl.push_back(mk(0,0,0, 1,16'h8000,2,0,0,0));
    tbl.push_back(mk(0,0,0, 1,16'h4000,2,0,0,0));
    tbl.push_back(mk(0,0,0,28,16'h0001,2,0,0,0));
    tbl.push_back(mk(0,0,0, 1,16'h0001,2,0,0,0));
    tbl.push_back(mk(0,0,0, 1,16'hFFFF,3,0,0,0));  // P2 missed
    tbl.push_back(mk(0,0,0, 3,16'hFFFF,3,0,0,0));
    tbl.push_back(mk(0,0,0, 1,16'hFF00,3,0,0,1));  // P1 wins

    for (int i = 0; i < tbl.size(); i++) begin
      apply($sformatf("row%0d", i), tbl[i]);
    end

    // OVER ignores any button activity
    for (int c = 0; c < 100; c++) begin
      button1 = 1'($urandom_range(0, 1));
      button2 = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      cmp($sformatf("over%0d", c), "led", led, 16'hFF00);
      cmp($sformatf("over%0d", c), "game_over", {15'd0, game_over}, 16'd1);
    end

    // Run 2: reset out of OVER, then reset in the middle of a sped-up rally
    apply("r2_rst",    mk(1,1,0, 1,16'h8000,0,0,0,0));
    apply("r2_idle",   mk(0,0,0, 1,16'h8000,0,0,0,0));
    apply("r2_serve",  mk(0,1,0, 1,16'h8000,0,0,0,0));
    apply("r2_fly",    mk(0,0,0,60,16'h0001,0,0,0,0));
    apply("r2_hit",    mk(0,0,1, 1,16'h0001,0,0,0,0));
    apply("r2_step",   mk(0,0,0, 3,16'h0002,0,0,0,0));
    apply("r2_mid",    mk(0,0,0, 2,16'h0002,0,0,0,0));
    apply("r2_rstmid", mk(1,1,1, 1,16'h8000,0,0,0,0));
    apply("r2_rel",    mk(0,0,0, 1,16'h8000,0,0,0,0));
    apply("r2_serve2", mk(0,1,0, 1,16'h8000,0,0,0,0));
    apply("r2_wait",   mk(0,0,0, 3,16'h8000,0,0,0,0));
    apply("r2_step4",  mk(0,0,0, 1,16'h4000,0,0,0,0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
